// File: rtl/fio_pkg.sv
// fio_pkg: register offsets, STATUS/CTRL bit indices and the byte type shared by fio_stream and fio_fifo
package fio_pkg;
  typedef logic [7:0] byte_t;
  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_DATA   = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int CT_RX_IE    = 0;
  localparam int CT_TX_IE    = 1;
  localparam int CT_RX_FLUSH = 2;
  localparam int CT_TX_FLUSH = 3;
endpackage

// File: rtl/fio_stream_fifo.sv
// fio_fifo: DEPTH-entry byte FIFO (mclk/reset_n; push/pop/flush in; din in; dout head, full, empty, count out); push when full succeeds only alongside a pop, flush wins
module fio_fifo
  import fio_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  byte_t         din,
  output byte_t         dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  byte_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = flush ? '0 : wr_q + AW'(do_push);
    rd_d    = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d   = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge mclk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/fio_stream.sv
// fio_stream: peripheral-mapped RX/TX byte FIFO pair (mclk/reset_n; per_* register bus; rx_* inbound and tx_* outbound streams; irq level)
module fio_stream
  import fio_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0180,
  parameter int DEPTH = 8
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  byte_t       rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output byte_t       tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  logic sel, rd, wr;
  logic [1:0] off;
  logic rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [AW:0] rx_cnt, tx_cnt;
  byte_t rx_head;
  logic rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
  logic [15:0] status;
  logic unused;
  assign unused = ^per_din[15:8];
  always_comb begin
    sel      = per_en && per_addr[13:2] == BASE_ADDR[14:3];
    off      = per_addr[1:0];
    rd       = sel && per_we == 2'b00;
    wr       = sel && per_we[0];
    rx_push  = rx_valid & ~rx_full;
    rx_pop   = rd && off == OFF_DATA;
    tx_push  = wr && off == OFF_DATA;
    tx_pop   = tx_valid & tx_ready;
    rx_flush = wr && off == OFF_CTRL && per_din[CT_RX_FLUSH];
    tx_flush = wr && off == OFF_CTRL && per_din[CT_TX_FLUSH];
    rx_ovf_d = (rx_valid & rx_full) | (rx_ovf_q & ~(wr && off == OFF_STATUS && per_din[ST_RX_OVF]));
    tx_ovf_d = (tx_push & tx_full & ~tx_pop) | (tx_ovf_q & ~(wr && off == OFF_STATUS && per_din[ST_TX_OVF]));
    rx_ie_d  = wr && off == OFF_CTRL ? per_din[CT_RX_IE] : rx_ie_q;
    tx_ie_d  = wr && off == OFF_CTRL ? per_din[CT_TX_IE] : tx_ie_q;
    status   = {10'd0, tx_ovf_q, rx_ovf_q, tx_full, tx_empty, rx_full, ~rx_empty};
    per_dout = !rd                ? 16'h0000 :
               off == OFF_STATUS ? status :
               off == OFF_DATA   ? {8'h00, rx_head} :
               off == OFF_CTRL   ? {14'd0, tx_ie_q, rx_ie_q} :
                                   {8'(tx_cnt), 8'(rx_cnt)};
  end
  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  assign irq = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty) | rx_ovf_q | tx_ovf_q;
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_ie_q  <= 1'b0;
      tx_ie_q  <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ie_q  <= rx_ie_d;
      tx_ie_q  <= tx_ie_d;
    end
  fio_fifo #(.DEPTH(DEPTH)) u_rx (
    .mclk(mclk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
  fio_fifo #(.DEPTH(DEPTH)) u_tx (
    .mclk(mclk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(per_din[7:0]), .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
endmodule
